// File: rtl/cltu_channel_arbiter_if.sv
// cltu_channel_arbiter_if: decoder channel A/B inputs and the arbitrated frame path outputs
interface cltu_channel_arbiter_if #(parameter int CNT_W = 16);
    logic             A_Data, A_En, A_Busy, A_End;
    logic             B_Data, B_En, B_Busy, B_End;
    logic             DataO, EnableO, FrameEndO, FrameAbortO;
    logic [1:0]       GrantO;
    logic [CNT_W-1:0] Grant_Cnt_A, Grant_Cnt_B, Drop_Cnt, Abort_Cnt;
    modport master (
        output A_Data, A_En, A_Busy, A_End, B_Data, B_En, B_Busy, B_End,
        input  DataO, EnableO, FrameEndO, FrameAbortO, GrantO,
        input  Grant_Cnt_A, Grant_Cnt_B, Drop_Cnt, Abort_Cnt
    );
    modport slave (
        input  A_Data, A_En, A_Busy, A_End, B_Data, B_En, B_Busy, B_End,
        output DataO, EnableO, FrameEndO, FrameAbortO, GrantO,
        output Grant_Cnt_A, Grant_Cnt_B, Drop_Cnt, Abort_Cnt
    );
endinterface

// File: rtl/cltu_channel_arbiter.sv
// cltu_channel_arbiter: locks the TC frame path to the first CLTU decoder channel that starts a CLTU
module cltu_channel_arbiter #(
    parameter bit              PRIO_A  = 1'b1,
    parameter int              TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = 24'd400000,
    parameter int              CNT_W   = 16
) (
    input logic                   ClkI,
    input logic                   Rst,
    cltu_channel_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOCK_A, LOCK_B, FLUSH_A, FLUSH_B} state_t;
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;
    state_t           state_q, state_d;
    logic             busy_a_q, busy_a_d, busy_b_q, busy_b_d, end_a_q, end_a_d, end_b_q, end_b_d;
    logic             rdy_q, rdy_d, data_q, data_d, en_q, en_d, fend_q, fend_d, fabort_q, fabort_d;
    logic [1:0]       grant_q, grant_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] gcnt_a_q, gcnt_a_d, gcnt_b_q, gcnt_b_d, drop_q, drop_d, abort_q, abort_d;
    logic             start_a, start_b, rise_end_a, rise_end_b, fall_a, fall_b;
    logic             idle, lock, flush, sel_b, x_en, x_data, x_fall, x_end, o_start;
    logic             win_a, win_b, timeout, abort, done, drop;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && !(&c)) ? c + 1'b1 : c;
    endfunction
    always_comb begin
        busy_a_d   = bus.A_Busy;
        busy_b_d   = bus.B_Busy;
        end_a_d    = bus.A_End;
        end_b_d    = bus.B_End;
        rdy_d      = 1'b1;
        // rdy_q masks the first cycle after reset so a channel already busy is not seen as starting
        start_a    = rdy_q & bus.A_Busy & ~busy_a_q;
        start_b    = rdy_q & bus.B_Busy & ~busy_b_q;
        rise_end_a = bus.A_End & ~end_a_q;
        rise_end_b = bus.B_End & ~end_b_q;
        fall_a     = busy_a_q & ~bus.A_Busy;
        fall_b     = busy_b_q & ~bus.B_Busy;
        idle       = state_q == IDLE;
        lock       = (state_q == LOCK_A) | (state_q == LOCK_B);
        flush      = (state_q == FLUSH_A) | (state_q == FLUSH_B);
        sel_b      = (state_q == LOCK_B) | (state_q == FLUSH_B);
        x_en       = sel_b ? bus.B_En : bus.A_En;
        x_data     = sel_b ? bus.B_Data : bus.A_Data;
        x_fall     = sel_b ? fall_b : fall_a;
        x_end      = sel_b ? rise_end_b : rise_end_a;
        o_start    = sel_b ? start_a : start_b;
        win_a      = idle & start_a & (~start_b | PRIO_A);
        win_b      = idle & start_b & (~start_a | ~PRIO_A);
        timeout    = ~x_en & (to_q == TO_LAST);
        abort      = lock & (x_fall ? ~x_end : timeout);
        done       = flush & ~x_en;
        drop       = idle ? (start_a & start_b) : lock ? o_start : (start_a | start_b);
        state_d    = win_a ? LOCK_A : win_b ? LOCK_B : (abort | done) ? IDLE :
                     (lock & x_fall) ? (sel_b ? FLUSH_B : FLUSH_A) : state_q;
        en_d       = (lock | flush) & x_en & ~abort;
        data_d     = en_d & x_data;
        fend_d     = done;
        fabort_d   = abort;
        grant_d    = {(state_d == LOCK_B) | (state_d == FLUSH_B), (state_d == LOCK_A) | (state_d == FLUSH_A)};
        to_d       = (idle | x_en) ? '0 : to_q + 1'b1;
        gcnt_a_d   = sat_inc(gcnt_a_q, win_a);
        gcnt_b_d   = sat_inc(gcnt_b_q, win_b);
        drop_d     = sat_inc(drop_q, drop);
        abort_d    = sat_inc(abort_q, abort);
    end
    always_ff @(posedge ClkI) begin
        if (!Rst) begin
            state_q  <= IDLE;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
            end_a_q  <= 1'b0;
            end_b_q  <= 1'b0;
            rdy_q    <= 1'b0;
            data_q   <= 1'b0;
            en_q     <= 1'b0;
            fend_q   <= 1'b0;
            fabort_q <= 1'b0;
            grant_q  <= 2'b00;
            to_q     <= '0;
            gcnt_a_q <= '0;
            gcnt_b_q <= '0;
            drop_q   <= '0;
            abort_q  <= '0;
        end else begin
            state_q  <= state_d;
            busy_a_q <= busy_a_d;
            busy_b_q <= busy_b_d;
            end_a_q  <= end_a_d;
            end_b_q  <= end_b_d;
            rdy_q    <= rdy_d;
            data_q   <= data_d;
            en_q     <= en_d;
            fend_q   <= fend_d;
            fabort_q <= fabort_d;
            grant_q  <= grant_d;
            to_q     <= to_d;
            gcnt_a_q <= gcnt_a_d;
            gcnt_b_q <= gcnt_b_d;
            drop_q   <= drop_d;
            abort_q  <= abort_d;
        end
    end
    assign bus.DataO       = data_q;
    assign bus.EnableO     = en_q;
    assign bus.FrameEndO   = fend_q;
    assign bus.FrameAbortO = fabort_q;
    assign bus.GrantO      = grant_q;
    assign bus.Grant_Cnt_A = gcnt_a_q;
    assign bus.Grant_Cnt_B = gcnt_b_q;
    assign bus.Drop_Cnt    = drop_q;
    assign bus.Abort_Cnt   = abort_q;
endmodule
